dct_block_scheduler: RTL and testbench

Shares one `dct_2d` instance among `N_REQ` pixel-block requesters, such as the Y, Cb and Cr planes, at 8x8-block granularity. Each grant is locked for exactly one block of `BLOCK_BEATS` beats. Outputs are tagged with the requester index on `tid`, and the number of blocks in flight inside the DCT pipeline is bounded by a credit counter. The block sits directly upstream of `dct_2d.video_i`; `dct_2d.dct_o` returns `tid` unchanged.

---
 rtl/dct_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/dct_block_scheduler.sv | 160 ++++++++++++++++
 tb/tb_dct_block_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT front end: block size and the
// state encoding of the block scheduler.
package dct_pkg;

   localparam int DCT_BLOCK_BEATS = 64;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } dct_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at last+1 and wraps,
// returning a one-hot grant and the matching index.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx
);

   logic found;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j == (int'(last) + i) % N)) begin
               found  = 1'b1;
               gnt[j] = 1'b1;
               idx    = IW'(j);
            end
         end
      end
   end

endmodule

// File: rtl/dct_block_scheduler.sv
// Shares one dct_2d among N_REQ block requesters, one 8x8 block per grant, with
// in-flight blocks bounded by credits. Define DCT_SCHED_STATS_EN for per-requester block counters.
module dct_block_scheduler
   import dct_pkg::*;
#(
   parameter  int PX_WIDTH     = 8,
   parameter  int N_REQ        = 3,
   parameter  int BLOCK_BEATS  = DCT_BLOCK_BEATS,
   parameter  int MAX_INFLIGHT = 2,
   localparam int TID_W        = $clog2(N_REQ)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N_REQ*PX_WIDTH-1:0] req_tdata_i,
   input  logic [N_REQ-1:0]          req_tvalid_i,
   output logic [N_REQ-1:0]          req_tready_o,
   output logic [PX_WIDTH-1:0]       dct_tdata_o,
   output logic                      dct_tvalid_o,
   input  logic                      dct_tready_i,
   output logic                      dct_tuser_o,
   output logic                      dct_tlast_o,
   output logic [TID_W-1:0]          dct_tid_o,
   input  logic                      blk_done_i,
   output logic [N_REQ-1:0]          grant_o,
   output logic                      credit_err_o
`ifdef DCT_SCHED_STATS_EN
   ,
   output logic [N_REQ*16-1:0]       blk_cnt_o
`endif
);

   localparam int CRED_W = $clog2(MAX_INFLIGHT + 1);
   localparam int BEAT_W = (BLOCK_BEATS > 2) ? $clog2(BLOCK_BEATS) : 1;
   localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(MAX_INFLIGHT);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BLOCK_BEATS - 1);
   localparam logic [TID_W-1:0]  LAST_RST  = TID_W'(N_REQ - 1);

   dct_sched_state_t  state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d, arb_gnt;
   logic [TID_W-1:0]  gidx_q, gidx_d, last_q, last_d, arb_idx;
   logic [CRED_W-1:0] credit_q, credit_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              err_q, err_d;
   logic              take, hs;

   rr_arbiter #(.N(N_REQ)) u_arb (
      .req  (req_tvalid_i),
      .last (last_q),
      .gnt  (arb_gnt),
      .idx  (arb_idx)
   );

   // Datapath is a pure mux of the granted requester; framing comes from beat_q.
   always_comb begin
      dct_tvalid_o = 1'b0;
      dct_tdata_o  = '0;
      dct_tuser_o  = 1'b0;
      dct_tlast_o  = 1'b0;
      dct_tid_o    = '0;
      req_tready_o = '0;
      if (state_q == GRANT) begin
         for (int k = 0; k < N_REQ; k++) begin
            if (gidx_q == TID_W'(k)) begin
               dct_tvalid_o = req_tvalid_i[k];
               dct_tdata_o  = req_tdata_i[k*PX_WIDTH +: PX_WIDTH];
            end
         end
         req_tready_o = grant_q & {N_REQ{dct_tready_i}};
         dct_tuser_o  = (beat_q == '0);
         dct_tlast_o  = (beat_q == BEAT_LAST);
         dct_tid_o    = gidx_q;
      end
   end

   assign hs           = dct_tvalid_o && dct_tready_i;
   assign grant_o      = grant_q;
   assign credit_err_o = err_q;

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      last_d   = last_q;
      beat_d   = beat_q;
      credit_d = credit_q;
      err_d    = err_q;
      take     = 1'b0;
      case (state_q)
         IDLE: begin
            if ((credit_q != '0) && (|req_tvalid_i)) begin
               take    = 1'b1;
               state_d = GRANT;
               grant_d = arb_gnt;
               gidx_d  = arb_idx;
               last_d  = arb_idx;
               beat_d  = '0;
            end
         end
         GRANT: begin
            if (hs) begin
               beat_d = beat_q + 1'b1;
               if (dct_tlast_o) begin
                  state_d = IDLE;
                  grant_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // A grant and a returned credit in the same cycle cancel out.
      if (take && !blk_done_i) begin
         credit_d = credit_q - 1'b1;
      end else if (!take && blk_done_i) begin
         if (credit_q == CRED_MAX) err_d = 1'b1;
         else                      credit_d = credit_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         last_q   <= LAST_RST;
         beat_q   <= '0;
         credit_q <= CRED_MAX;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         last_q   <= last_d;
         beat_q   <= beat_d;
         credit_q <= credit_d;
         err_q    <= err_d;
      end
   end

`ifdef DCT_SCHED_STATS_EN
   logic [N_REQ*16-1:0] blk_cnt_q, blk_cnt_d;

   always_comb begin
      blk_cnt_d = blk_cnt_q;
      for (int k = 0; k < N_REQ; k++) begin
         if (hs && dct_tlast_o && (gidx_q == TID_W'(k))) begin
            blk_cnt_d[k*16 +: 16] = blk_cnt_q[k*16 +: 16] + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) blk_cnt_q <= '0;
      else       blk_cnt_q <= blk_cnt_d;
   end

   assign blk_cnt_o = blk_cnt_q;
`endif

endmodule

// File: tb/tb_dct_block_scheduler.sv
// Scoreboard bench for dct_block_scheduler: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted DCT beat.
module tb_dct_block_scheduler;

   localparam int N   = 3;
   localparam int PXW = 8;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic [N*PXW-1:0] req_tdata_i;
   logic [N-1:0]   req_tvalid_i;
   logic [N-1:0]   req_tready_o;
   logic [PXW-1:0] dct_tdata_o;
   logic           dct_tvalid_o;
   logic           dct_tready_i;
   logic           dct_tuser_o;
   logic           dct_tlast_o;
   logic [1:0]     dct_tid_o;
   logic           blk_done_i;
   logic [N-1:0]   grant_o;
   logic           credit_err_o;
`ifdef DCT_SCHED_STATS_EN
   logic [N*16-1:0] blk_cnt_o;
`endif

   dct_block_scheduler dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .req_tdata_i  (req_tdata_i),
      .req_tvalid_i (req_tvalid_i),
      .req_tready_o (req_tready_o),
      .dct_tdata_o  (dct_tdata_o),
      .dct_tvalid_o (dct_tvalid_o),
      .dct_tready_i (dct_tready_i),
      .dct_tuser_o  (dct_tuser_o),
      .dct_tlast_o  (dct_tlast_o),
      .dct_tid_o    (dct_tid_o),
      .blk_done_i   (blk_done_i),
      .grant_o      (grant_o),
      .credit_err_o (credit_err_o)
`ifdef DCT_SCHED_STATS_EN
      ,
      .blk_cnt_o    (blk_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [7:0] data;
      logic [1:0] tid;
      logic       user;
      logic       last;
   } beat_t;

   beat_t sb[$];
   int    n_checks = 0;
   int    n_err    = 0;

   // Requester model: requester k sends {k, beat} and owns blocks_req[k] blocks.
   int         blocks_req[N];
   int         blocks_done[N];
   logic [5:0] src_beat[N];
   logic [N-1:0] stall;
   logic       blk_done_man;
   logic       auto_en;
   logic       gap_en;
   logic [15:0] done_sr;
   int         cyc = 0;
   int         last_cyc = 0;
   logic       have_last = 1'b0;

   initial begin
      for (int k = 0; k < N; k++) begin
         blocks_req[k]  = 0;
         blocks_done[k] = 0;
      end
   end

   always_comb begin
      req_tvalid_i = '0;
      req_tdata_i  = '0;
      for (int k = 0; k < N; k++) begin
         req_tvalid_i[k] = (blocks_done[k] < blocks_req[k]) && !stall[k];
         req_tdata_i[k*PXW +: PXW] = {2'(k), src_beat[k]};
      end
   end

   always @(posedge clk_i) begin
      for (int k = 0; k < N; k++) begin
         if (rst_i) begin
            src_beat[k] <= '0;
         end else if (req_tvalid_i[k] && req_tready_o[k]) begin
            src_beat[k] <= src_beat[k] + 6'd1;
            if (src_beat[k] == 6'd63) blocks_done[k] <= blocks_done[k] + 1;
         end
      end
   end

   // DCT completion model: blk_done 10 cycles after each accepted tlast.
   always @(posedge clk_i) begin
      cyc <= cyc + 1;
      if (rst_i) done_sr <= '0;
      else       done_sr <= {done_sr[14:0], auto_en && dct_tvalid_o && dct_tready_i && dct_tlast_o};
   end
   assign blk_done_i = blk_done_man | done_sr[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk_i) begin
      beat_t e;
      if (!gap_en) have_last = 1'b0;
      if (!rst_i && dct_tvalid_o && dct_tready_i) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_beat: tid %0d data %0h but no beat expected at %0t",
                     dct_tid_o, dct_tdata_o, $time);
         end else begin
            e = sb.pop_front();
            check("beat_data", 32'(dct_tdata_o), 32'(e.data));
            check("beat_tid", 32'(dct_tid_o), 32'(e.tid));
            check("beat_tuser", 32'(dct_tuser_o), 32'(e.user));
            check("beat_tlast", 32'(dct_tlast_o), 32'(e.last));
            check("beat_grant", 32'(grant_o), 32'(1) << e.tid);
            if (gap_en && dct_tuser_o && have_last) check("idle_gap", 32'(cyc - last_cyc), 32'd2);
            if (dct_tlast_o) begin
               have_last = 1'b1;
               last_cyc  = cyc;
            end
         end
      end
   end

   task automatic push_beats(input int k, input int n);
      beat_t e;
      for (int b = 0; b < n; b++) begin
         e.data = 8'(k * 64 + b);
         e.tid  = 2'(k);
         e.user = (b == 0);
         e.last = (b == 63);
         sb.push_back(e);
      end
   endtask

   task automatic push_block(input int k);
      push_beats(k, 64);
   endtask

   task automatic wait_level(input int level, input int max_cyc, input string name);
      int c = 0;
      while (sb.size() > level && c < max_cyc) begin
         @(posedge clk_i);
         c++;
      end
      if (sb.size() > level) begin
         n_checks++;
         n_err++;
         $display("FAIL %s: %0d beats pending after %0d cycles", name, sb.size(), c);
         sb.delete();
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_grant"}, 32'(grant_o), 32'd0);
      check({tag, "_ready"}, 32'(req_tready_o), 32'd0);
      check({tag, "_tvalid"}, 32'(dct_tvalid_o), 32'd0);
      check({tag, "_tuser"}, 32'(dct_tuser_o), 32'd0);
      check({tag, "_tlast"}, 32'(dct_tlast_o), 32'd0);
      check({tag, "_tid"}, 32'(dct_tid_o), 32'd0);
      check({tag, "_err"}, 32'(credit_err_o), 32'd0);
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      for (int k = 0; k < N; k++) blocks_req[k] = blocks_done[k];
      sb.delete();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   task automatic pulse_done();
      @(posedge clk_i);
      #1 blk_done_man = 1'b1;
      @(posedge clk_i);
      #1 blk_done_man = 1'b0;
   endtask

   initial begin
      int  c;
      int  sc;
      bit  stalled;

      rst_i        = 1'b1;
      dct_tready_i = 1'b1;
      blk_done_man = 1'b0;
      stall        = '0;
      auto_en      = 1'b0;
      gap_en       = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 check_reset("por");
      rst_i = 1'b0;

      // Single requester: one arbitration cycle, then 64 beats tagged tid=1.
      blocks_req[1] = 1;
      push_block(1);
      #1 check("t1_idle_tvalid", 32'(dct_tvalid_o), 32'd0);
      @(posedge clk_i);
      #1;
      check("t1_first_tvalid", 32'(dct_tvalid_o), 32'd1);
      check("t1_first_tuser", 32'(dct_tuser_o), 32'd1);
      check("t1_first_tid", 32'(dct_tid_o), 32'd1);
      wait_level(0, 200, "t1_drain");

      // Fairness: everyone valid, credits returned 10 cycles after each tlast.
      do_reset();
      auto_en = 1'b1;
      gap_en  = 1'b1;
      for (int k = 0; k < N; k++) blocks_req[k] += 2;
      for (int r = 0; r < 2; r++) for (int k = 0; k < N; k++) push_block(k);
      wait_level(0, 1000, "t2_drain");
      #1 gap_en = 1'b0;
      auto_en = 1'b0;
      repeat (15) @(posedge clk_i);
      #1 check("t2_no_err", 32'(credit_err_o), 32'd0);

      // Credit starvation: two blocks issue, the third waits for one blk_done.
      do_reset();
      blocks_req[0] += 3;
      for (int r = 0; r < 3; r++) push_block(0);
      wait_level(64, 400, "t3_two_blocks");
      repeat (20) @(posedge clk_i);
      #1;
      check("t3_starve_grant", 32'(grant_o), 32'd0);
      check("t3_starve_ready", 32'(req_tready_o), 32'd0);
      check("t3_starve_pending", 32'(sb.size()), 32'd64);
      blk_done_man = 1'b1;
      @(posedge clk_i);
      #1 blk_done_man = 1'b0;
      check("t3_arb_tvalid", 32'(dct_tvalid_o), 32'd0);
      @(posedge clk_i);
      #1;
      check("t3_resume_tvalid", 32'(dct_tvalid_o), 32'd1);
      check("t3_resume_tuser", 32'(dct_tuser_o), 32'd1);
      wait_level(0, 200, "t3_drain");

      // Grant coincident with blk_done keeps one credit: exactly two blocks run.
      pulse_done();
      blocks_req[1] += 3;
      blk_done_man = 1'b1;
      push_block(1);
      push_block(1);
      @(posedge clk_i);
      #1 blk_done_man = 1'b0;
      check("t4_grant_tid", 32'(dct_tid_o), 32'd1);
      wait_level(0, 400, "t4_drain");
      repeat (20) @(posedge clk_i);
      #1;
      check("t4_hold_grant", 32'(grant_o), 32'd0);
      check("t4_hold_tvalid", 32'(dct_tvalid_o), 32'd0);
      check("t4_err_clear", 32'(credit_err_o), 32'd0);
      push_block(1);
      pulse_done();
      wait_level(0, 200, "t4_third");
      pulse_done();
      pulse_done();
      check("t4_full_no_err", 32'(credit_err_o), 32'd0);
      pulse_done();
      check("t4_overflow_err", 32'(credit_err_o), 32'd1);
      repeat (5) @(posedge clk_i);
      #1 check("t4_err_sticky", 32'(credit_err_o), 32'd1);

      // Reset at beat 21 of a req2 block; afterwards req0 must win first.
      blocks_req[2] += 1;
      push_beats(2, 21);
      wait_level(0, 100, "t5_partial");
      #1 rst_i = 1'b1;
      dct_tready_i = 1'b0;
      @(posedge clk_i);
      #1 check_reset("mid");
      blocks_req[2] = blocks_done[2];
      rst_i        = 1'b0;
      dct_tready_i = 1'b1;
      blocks_req[0] += 1;
      blocks_req[2] += 1;
      push_block(0);
      push_block(2);
      wait_level(0, 300, "t5_drain");

      // Backpressure: random ready, req0 drops valid at beat 30 for 5 cycles.
      pulse_done();
      pulse_done();
      blocks_req[0] += 1;
      push_block(0);
      c       = 0;
      sc      = 0;
      stalled = 1'b0;
      while (sb.size() != 0 && c < 2000) begin
         @(posedge clk_i);
         #1;
         c++;
         dct_tready_i = 1'($urandom_range(0, 1));
         if (!stalled && src_beat[0] == 6'd30) begin
            stalled  = 1'b1;
            stall[0] = 1'b1;
            sc       = 5;
         end else if (sc > 0) begin
            sc--;
            if (sc == 0) stall[0] = 1'b0;
         end
      end
      dct_tready_i = 1'b1;
      stall        = '0;
      check("t6_pending", 32'(sb.size()), 32'd0);
      check("t6_end_grant", 32'(grant_o), 32'd0);
      sb.delete();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
